// File: rtl/time_count_pkg.sv
// Shared constants and types for the MM:SS elapsed-time display:
// segment patterns, BCD digit limits and the default tick divisor.
package time_count_pkg;

    localparam int unsigned DIGIT_W          = 4;
    localparam int unsigned SEG_W            = 7;
    localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;

    localparam logic [DIGIT_W-1:0] BCD_UNITS_MAX = DIGIT_W'(9);
    localparam logic [DIGIT_W-1:0] BCD_TENS_MAX  = DIGIT_W'(5);

    // Active-low segments packed as {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

    typedef struct packed {
        logic [DIGIT_W-1:0] m1;
        logic [DIGIT_W-1:0] m0;
        logic [DIGIT_W-1:0] s1;
        logic [DIGIT_W-1:0] s0;
    } time_digits_t;

endpackage

// File: rtl/hex_decoder.sv
// Hex digit to active-low 7-segment pattern, full 0-F range.
module hex_decoder
    import time_count_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   seg
);

    always_comb begin
        seg = SEG_0;
        case (digit)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_0;
        endcase
    end

endmodule

// File: rtl/rate_divider_fast.sv
// Free-running divider producing a one-cycle enable pulse every TICK_DIV
// enabled clocks; the count freezes while enable is low.
module rate_divider_fast
    import time_count_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    // Reset gating keeps a coincident reset from advancing the digits
    assign tick = enable && !reset && (div_cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (enable) begin
            if (div_cnt == CNT_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/time_count.sv
// MM:SS play-time counter: divider tick advances a BCD digit chain that is
// decoded onto four 7-segment displays.
module time_count
    import time_count_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             SW,
    output logic [SEG_W-1:0] HEX0,
    output logic [SEG_W-1:0] HEX1,
    output logic [SEG_W-1:0] HEX2,
    output logic [SEG_W-1:0] HEX3
);

    logic         tick;
    time_digits_t cnt;
    time_digits_t cnt_next;

    rate_divider_fast #(
        .TICK_DIV (TICK_DIV)
    ) u_div (
        .clock  (CLOCK_50),
        .reset  (reset),
        .enable (SW),
        .tick   (tick)
    );

    // Ripple carry s0 -> s1 -> m0 -> m1; 59:59 wraps to 00:00
    always_comb begin
        cnt_next = cnt;
        if (tick) begin
            if (cnt.s0 == BCD_UNITS_MAX) begin
                cnt_next.s0 = '0;
                if (cnt.s1 == BCD_TENS_MAX) begin
                    cnt_next.s1 = '0;
                    if (cnt.m0 == BCD_UNITS_MAX) begin
                        cnt_next.m0 = '0;
                        if (cnt.m1 == BCD_TENS_MAX) begin
                            cnt_next.m1 = '0;
                        end else begin
                            cnt_next.m1 = cnt.m1 + DIGIT_W'(1);
                        end
                    end else begin
                        cnt_next.m0 = cnt.m0 + DIGIT_W'(1);
                    end
                end else begin
                    cnt_next.s1 = cnt.s1 + DIGIT_W'(1);
                end
            end else begin
                cnt_next.s0 = cnt.s0 + DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    hex_decoder u_hex0 (.digit(cnt.s0), .seg(HEX0));
    hex_decoder u_hex1 (.digit(cnt.s1), .seg(HEX1));
    hex_decoder u_hex2 (.digit(cnt.m0), .seg(HEX2));
    hex_decoder u_hex3 (.digit(cnt.m1), .seg(HEX3));

endmodule

// File: tb/tb_time_count.sv
// Directed bench for time_count with a fast divider and a standalone
// hex_decoder sweep; expected values come from a seconds/phase model.
module tb_time_count;

    localparam int unsigned TDIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic [3:0] dec_in;
    logic [6:0] dec_out;

    int checks = 0;
    int errors = 0;

    // Model state: divider phase and elapsed seconds
    int exp_div  = 0;
    int exp_secs = 0;

    logic [6:0] seg_tab [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    time_count #(.TICK_DIV(TDIV)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .SW       (sw),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3)
    );

    hex_decoder u_dec (.digit(dec_in), .seg(dec_out));

    always #5 clk = ~clk;

    task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock edge with the model updated the way the edge should act
    task automatic step(input logic r, input logic s);
        reset = r;
        sw    = s;
        @(posedge clk);
        if (r) begin
            exp_div  = 0;
            exp_secs = 0;
        end else if (s) begin
            if (exp_div == int'(TDIV) - 1) begin
                exp_div  = 0;
                exp_secs = (exp_secs + 1) % 3600;
            end else begin
                exp_div++;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        int mm, ss;
        mm = exp_secs / 60;
        ss = exp_secs % 60;
        chk7({tag, "_hex0"}, hex0, seg_tab[ss % 10]);
        chk7({tag, "_hex1"}, hex1, seg_tab[ss / 10]);
        chk7({tag, "_hex2"}, hex2, seg_tab[mm % 10]);
        chk7({tag, "_hex3"}, hex3, seg_tab[mm / 10]);
        chk1({tag, "_tick"}, dut.tick,
             sw && !reset && (exp_div == int'(TDIV) - 1));
    endtask

    initial begin
        reset  = 1'b1;
        sw     = 1'b1;
        dec_in = 4'h0;

        // Reset held two cycles with SW high
        step(1'b1, 1'b1);
        check_all("reset1");
        step(1'b1, 1'b1);
        check_all("reset2");

        // Basic count: 40 enabled cycles -> 00:10
        for (int c = 1; c <= 40; c++) begin
            step(1'b0, 1'b1);
            check_all($sformatf("count%0d", c));
        end
        chk7("basic_hex1_one", hex1, 7'b1111001);
        chk7("basic_hex0_zero", hex0, 7'b1000000);

        // Advance to the tick cycle at 00:59, then check 01:00
        while (!(exp_secs == 59 && exp_div == int'(TDIV) - 1)) step(1'b0, 1'b1);
        check_all("at_0059");
        step(1'b0, 1'b1);
        check_all("carry_0100");
        chk7("carry_hex2_one", hex2, 7'b1111001);

        // Advance to the tick cycle at 59:59, then full wrap
        while (!(exp_secs == 3599 && exp_div == int'(TDIV) - 1)) step(1'b0, 1'b1);
        check_all("at_5959");
        step(1'b0, 1'b1);
        check_all("wrap_0000");
        chk7("wrap_hex3_zero", hex3, 7'b1000000);

        // Pause: two enabled cycles, ten paused, then resume
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check_all("pre_pause");
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0);
            check_all($sformatf("pause%0d", c));
        end
        step(1'b0, 1'b1);
        check_all("resume1");
        chk1("resume_tick_high", dut.tick, 1'b1);
        step(1'b0, 1'b1);
        check_all("resume2");
        chk7("resume_hex0_one", hex0, 7'b1111001);

        // Reset on a tick cycle wins over the increment
        while (exp_div != int'(TDIV) - 1) step(1'b0, 1'b1);
        check_all("pre_rst_tick");
        step(1'b1, 1'b1);
        check_all("rst_on_tick");
        chk1("rst_div_zero", (dut.u_div.div_cnt == '0), 1'b1);
        step(1'b0, 1'b1);
        check_all("post_rst1");

        // Standalone decoder sweep
        for (int i = 0; i < 16; i++) begin
            dec_in = 4'(i);
            #1;
            chk7($sformatf("dec_%0h", i), dec_out, seg_tab[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_count.md
# time_count

Elapsed-time display block for the game board: counts play time as MM:SS from the 50 MHz board clock and drives four 7-segment displays (HEX3..HEX0). A parameterised rate divider generates a one-cycle tick per second; BCD digit counters advance on that tick; four hex decoders convert the digits to active-low segment patterns. The top level instantiates it with its enable tied to SW[17] and its outputs to HEX0..HEX3.

## Interface
Parameters:
- TICK_DIV, 50_000_000, CLOCK_50 cycles per count tick (1 s at 50 MHz); benches override with a small value (≥2).

Ports:
- CLOCK_50  in  1  board clock; all state on its rising edge.
- reset  in  1  synchronous, active-high; clears divider and all digits.
- SW  in  1  count enable; 1 = run, 0 = pause (hold all state).
- HEX0  out  7  seconds units digit, active-low segments, bit0=a … bit6=g.
- HEX1  out  7  seconds tens digit.
- HEX2  out  7  minutes units digit.
- HEX3  out  7  minutes tens digit.

One clock; reset is synchronous and active-high.

## Operation
- Divider: counter `div_cnt` width ceil(log2(TICK_DIV)); when SW=1, increments each cycle; at TICK_DIV-1 wraps to 0 and asserts `tick` for exactly that one cycle. When SW=0, div_cnt holds and tick=0. Tick is a pulse/enable, never used as a clock.
- Digits (4-bit BCD each): s0 0–9, s1 0–5, m0 0–9, m1 0–5.
- On tick: s0++; s0 9→0 carries into s1; s1 5→0 (with s0 carry) carries into m0; m0 9→0 carries into m1; m1 5→0. 59:59 + tick → 00:00 (full wrap, no saturation, no overflow flag).
- Decoder (combinational, per digit), active-low a..g as {g,f,e,d,c,b,a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Full 0–F table implemented even though counters never exceed 9.
- HEXn = decode(digit n).

## Timing
- Reset: div_cnt=0, all digits 0; from the cycle after reset is sampled, HEX0..HEX3 = 1000000 ("0").
- Reset dominates SW in the same cycle.
- With SW held 1 from reset release, first tick on cycle TICK_DIV (counting the first enabled edge as 1); digits update on the edge where tick=1 is sampled, so HEX changes one cycle after tick is high; subsequent ticks every TICK_DIV cycles.
- SW 1→0 freezes div_cnt mid-period; 0→1 resumes from the frozen value (partial period preserved).
- Decoder adds zero latency (pure combinational from digit registers).
- Reset mid-period or mid-carry: all state cleared on that edge; no partial carry survives.

## Structure
- Shared package: SEG_* active-low constants for 0–F, BCD limits (9, 5), default TICK_DIV.
- Sub-module rate_divider_fast (ports: clock, reset, enable, tick; parameter TICK_DIV).
- Sub-module hex_decoder (4-bit in, 7-bit active-low out), instantiated four times; also reused by the score displays.
- Digit counter chain lives in time_count itself.

## Test plan
(TICK_DIV=4 unless stated)
- Reset: assert reset 2 cycles with SW=1 → HEX3..0 all 1000000, no tick during reset.
- Basic count: SW=1 for 40 cycles after reset → tick every 4th cycle, HEX0 shows 0→9 then 0, HEX1=1111001 ("1") after 40 cycles.
- Rollover: preload via 3599 ticks (59:59) then one more tick → all four digits 1000000 (00:00); 59→100 carry at 00:59→01:00 checked.
- Pause: SW=1 for 2 cycles, SW=0 for 10, SW=1 → next tick exactly 2 cycles after re-enable; digits unchanged during pause.
- Reset priority: reset=1 and SW=1 on the tick cycle → digits 0, no increment, div_cnt=0.
- Decoder sweep: standalone hex_decoder inputs 0x0–0xF → exact table above.
